// File: rtl/delay_tap_ctrl_if.sv
// delay_tap_ctrl_if: data, config and status bundle for delay_tap_ctrl.
// DELAY_TAP_CTRL_STATS_EN adds the drop_cnt / rej_cnt status counters.
interface delay_tap_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 5
);
  logic             ena;
  logic [WIDTH-1:0] d;
  logic             d_valid;
  logic             cfg_stb;
  logic [CNT_W-1:0] cfg_delay;
  logic             cfg_ack;
  logic             cfg_err;
  logic             busy;
  logic [CNT_W-1:0] cur_delay;
  logic [WIDTH-1:0] q;
  logic             q_valid;
`ifdef DELAY_TAP_CTRL_STATS_EN
  logic [15:0]      drop_cnt;
  logic [15:0]      rej_cnt;

  modport master (
    output ena, d, d_valid,
    output cfg_stb, cfg_delay,
    input  cfg_ack, cfg_err, busy,
    input  cur_delay, q, q_valid,
    input  drop_cnt, rej_cnt
  );

  modport slave (
    input  ena, d, d_valid,
    input  cfg_stb, cfg_delay,
    output cfg_ack, cfg_err, busy,
    output cur_delay, q, q_valid,
    output drop_cnt, rej_cnt
  );
`else
  modport master (
    output ena, d, d_valid,
    output cfg_stb, cfg_delay,
    input  cfg_ack, cfg_err, busy,
    input  cur_delay, q, q_valid
  );

  modport slave (
    input  ena, d, d_valid,
    input  cfg_stb, cfg_delay,
    output cfg_ack, cfg_err, busy,
    output cur_delay, q, q_valid
  );
`endif
endinterface

// File: rtl/delay_tap_ctrl.sv
// delay_tap_ctrl: retunable delay line with flush/refill sequencing.
// DELAY_TAP_CTRL_STATS_EN adds dropped/rejected request counters.
module delay_tap_ctrl #(
  parameter int WIDTH         = 8,
  parameter int MAX_CYCLES    = 16,
  parameter int DEFAULT_DELAY = 1,
  parameter int CNT_W         = $clog2(MAX_CYCLES+1)
) (
  input logic              clk,
  input logic              rst,
  delay_tap_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_RUN,
    S_FLUSH,
    S_FILL
  } state_t;

  localparam logic [CNT_W-1:0] MAXD = CNT_W'(MAX_CYCLES);
  localparam logic [CNT_W-1:0] DEFD = CNT_W'(DEFAULT_DELAY);

  state_t           state, state_n;
  logic [CNT_W-1:0] cur_delay;
  logic [CNT_W-1:0] fcnt;
  logic             ack, err;
  logic             ack_n, err_n;
  logic             load, flush;
  logic             fill_clr, fill_inc;

  logic [WIDTH-1:0]      sd [MAX_CYCLES];
  logic [MAX_CYCLES-1:0] sv;

  logic [WIDTH-1:0] tap_d;
  logic             tap_v;
  logic             busy;

  assign busy = (state != S_RUN);

  // Next state and control strobes of the retune sequencer
  always_comb begin
    state_n  = state;
    ack_n    = 1'b0;
    err_n    = 1'b0;
    load     = 1'b0;
    flush    = 1'b0;
    fill_clr = 1'b0;
    fill_inc = 1'b0;
    unique case (state)
      S_RUN: begin
        if (bus.cfg_stb) begin
          if (bus.cfg_delay > MAXD) begin
            ack_n = 1'b1;
            err_n = 1'b1;
          end else begin
            load    = 1'b1;
            state_n = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        flush    = 1'b1;
        fill_clr = 1'b1;
        if (cur_delay == '0) begin
          state_n = S_RUN;
          ack_n   = 1'b1;
        end else begin
          state_n = S_FILL;
        end
      end
      S_FILL: begin
        if (bus.ena) begin
          if (fcnt == cur_delay - CNT_W'(1)) begin
            state_n = S_RUN;
            ack_n   = 1'b1;
          end else begin
            fill_inc = 1'b1;
          end
        end
      end
      default: state_n = S_RUN;
    endcase
  end

  // Sequencer state, active delay, fill counter and ack pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_RUN;
      cur_delay <= DEFD;
      fcnt      <= '0;
      ack       <= 1'b0;
      err       <= 1'b0;
    end else begin
      state <= state_n;
      ack   <= ack_n;
      err   <= err_n;
      if (load)
        cur_delay <= bus.cfg_delay;
      if (fill_clr)
        fcnt <= '0;
      else if (fill_inc)
        fcnt <= fcnt + CNT_W'(1);
    end
  end

  // Shift stages; a flush invalidates every stage but keeps data
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAX_CYCLES; i++)
        sd[i] <= '0;
      sv <= '0;
    end else begin
      if (bus.ena) begin
        sd[0] <= bus.d;
        for (int i = 1; i < MAX_CYCLES; i++)
          sd[i] <= sd[i-1];
      end
      if (flush) begin
        sv <= '0;
      end else if (bus.ena) begin
        sv[0] <= bus.d_valid;
        for (int i = 1; i < MAX_CYCLES; i++)
          sv[i] <= sv[i-1];
      end
    end
  end

  // Output tap: delay 0 bypasses the stages entirely
  always_comb begin
    tap_d = bus.d;
    tap_v = bus.d_valid;
    for (int i = 0; i < MAX_CYCLES; i++) begin
      if (cur_delay == CNT_W'(i + 1)) begin
        tap_d = sd[i];
        tap_v = sv[i];
      end
    end
  end

  assign bus.q         = tap_d;
  assign bus.q_valid   = tap_v & ~busy;
  assign bus.busy      = busy;
  assign bus.cfg_ack   = ack;
  assign bus.cfg_err   = err;
  assign bus.cur_delay = cur_delay;

`ifdef DELAY_TAP_CTRL_STATS_EN
  logic [15:0] drop_cnt;
  logic [15:0] rej_cnt;

  // Saturating counts of dropped and rejected requests
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
      rej_cnt  <= '0;
    end else begin
      if (busy && bus.cfg_stb && drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 16'd1;
      if (err_n && rej_cnt != 16'hFFFF)
        rej_cnt <= rej_cnt + 16'd1;
    end
  end

  assign bus.drop_cnt = drop_cnt;
  assign bus.rej_cnt  = rej_cnt;
`endif

endmodule

// File: tb/tb_delay_tap_ctrl.sv
// tb_delay_tap_ctrl: directed and random checks of delay_tap_ctrl
// against a history-based reference model.
module tb_delay_tap_ctrl;

  localparam int WIDTH = 8;
  localparam int MAXC  = 16;
  localparam int DEF   = 1;
  localparam int CNT_W = $clog2(MAXC+1);

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  delay_tap_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus();

  delay_tap_ctrl #(
    .WIDTH(WIDTH),
    .MAX_CYCLES(MAXC),
    .DEFAULT_DELAY(DEF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: history of samples, newest at index 0
  logic [WIDTH-1:0] h_d [MAXC];
  bit               h_v [MAXC];
  int               m_delay;
  bit               m_flush;
  int               m_rem;
  bit               m_ack;
  bit               m_err;
  int               m_drop;
  int               m_rej;
  bit               armed = 1'b0;
  bit               obs_busy;
  bit               obs_ack;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0h exp=%0h",
               tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < MAXC; i++) begin
      h_d[i] = '0;
      h_v[i] = 1'b0;
    end
    m_delay = DEF;
    m_flush = 1'b0;
    m_rem   = 0;
    m_ack   = 1'b0;
    m_err   = 1'b0;
    m_drop  = 0;
    m_rej   = 0;
  endtask

  task automatic model_edge(input bit r, input bit e,
                            input logic [WIDTH-1:0] dd,
                            input bit dv, input bit s,
                            input int cd);
    bit bsy;
    bit na;
    bit ne;
    if (r) begin
      model_reset();
      return;
    end
    bsy = m_flush || (m_rem > 0);
    na  = 1'b0;
    ne  = 1'b0;
    if (bsy && s && m_drop < 65535)
      m_drop++;
    if (e) begin
      for (int i = MAXC - 1; i > 0; i--) begin
        h_d[i] = h_d[i-1];
        h_v[i] = h_v[i-1];
      end
      h_d[0] = dd;
      h_v[0] = dv;
    end
    if (m_flush) begin
      for (int i = 0; i < MAXC; i++)
        h_v[i] = 1'b0;
      m_flush = 1'b0;
      if (m_delay == 0) na = 1'b1;
      else m_rem = m_delay;
    end else if (m_rem > 0) begin
      if (e) begin
        m_rem--;
        if (m_rem == 0) na = 1'b1;
      end
    end else if (s) begin
      if (cd > MAXC) begin
        na = 1'b1;
        ne = 1'b1;
        if (m_rej < 65535) m_rej++;
      end else begin
        m_delay = cd;
        m_flush = 1'b1;
      end
    end
    m_ack = na;
    m_err = ne;
  endtask

  task automatic check_outputs(input logic [WIDTH-1:0] dd,
                               input bit dv);
    bit               bsy;
    logic [WIDTH-1:0] eq;
    bit               ev;
    bsy = m_flush || (m_rem > 0);
    if (m_delay == 0) begin
      eq = dd;
      ev = dv;
    end else begin
      eq = h_d[m_delay-1];
      ev = h_v[m_delay-1];
    end
    if (bsy) ev = 1'b0;
    check("busy", 32'(bus.busy), 32'(bsy));
    check("ack", 32'(bus.cfg_ack), 32'(m_ack));
    check("err", 32'(bus.cfg_ack & bus.cfg_err), 32'(m_err));
    check("cur_delay", 32'(bus.cur_delay), 32'(m_delay));
    check("q", 32'(bus.q), 32'(eq));
    check("q_valid", 32'(bus.q_valid), 32'(ev));
`ifdef DELAY_TAP_CTRL_STATS_EN
    check("drop_cnt", 32'(bus.drop_cnt), 32'(m_drop));
    check("rej_cnt", 32'(bus.rej_cnt), 32'(m_rej));
`endif
  endtask

  task automatic step(input bit r, input bit e,
                      input logic [WIDTH-1:0] dd,
                      input bit dv, input bit s,
                      input int cd);
    @(negedge clk);
    rst           = r;
    bus.ena       = e;
    bus.d         = dd;
    bus.d_valid   = dv;
    bus.cfg_stb   = s;
    bus.cfg_delay = CNT_W'(cd);
    #1;
    obs_busy = bus.busy;
    obs_ack  = bus.cfg_ack;
    if (armed) check_outputs(dd, dv);
    @(posedge clk);
    model_edge(r, e, dd, dv, s, cd);
    if (r) armed = 1'b1;
  endtask

  task automatic retune(input int cd, input bit toggle,
                        input string tag, input int exp_busy,
                        input int exp_ack);
    int nb;
    int ka;
    nb = 0;
    ka = 0;
    step(0, 1, 8'($urandom), 1, 1, cd);
    for (int k = 1; k <= 40 && ka == 0; k++) begin
      step(0, toggle ? bit'(k % 2) : 1'b1,
           8'($urandom), 1, 0, 0);
      if (obs_busy) nb++;
      if (obs_ack) ka = k;
    end
    check({tag, "_busy_len"}, 32'(nb), 32'(exp_busy));
    check({tag, "_ack_cycle"}, 32'(ka), 32'(exp_ack));
  endtask

  initial begin
    bit s;
    int cd;
    model_reset();
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    check("rst_cur_delay", 32'(bus.cur_delay), 32'(DEF));

    for (int i = 1; i <= 8; i++)
      step(0, 1, 8'(i), 1, 0, 0);

    retune(4, 1'b0, "d4", 5, 6);
    for (int i = 0; i < 10; i++)
      step(0, 1, 8'(8'h40 + i), 1, 0, 0);

    retune(4, 1'b1, "d4_ena", 9, 10);
    for (int i = 0; i < 8; i++)
      step(0, 1, 8'($urandom), 1, 0, 0);

    retune(17, 1'b0, "d17", 0, 1);
    retune(0, 1'b0, "d0", 1, 2);
    for (int i = 0; i < 4; i++)
      step(0, 1, 8'($urandom), bit'($urandom), 0, 0);

    step(0, 1, 8'h11, 1, 1, 4);
    step(0, 1, 8'h12, 1, 0, 0);
    step(0, 1, 8'h13, 1, 0, 0);
    step(0, 1, 8'h14, 1, 1, 9);
    step(0, 1, 8'h15, 1, 0, 0);
`ifdef DELAY_TAP_CTRL_STATS_EN
    check("drop_before_rst", 32'(bus.drop_cnt), 32'd1);
`endif
    step(1, 1, 8'h16, 1, 0, 0);
    step(0, 1, 8'h17, 1, 0, 0);
    check("cur_after_rst", 32'(bus.cur_delay), 32'(DEF));
`ifdef DELAY_TAP_CTRL_STATS_EN
    check("drop_after_rst", 32'(bus.drop_cnt), 32'd0);
`endif
    for (int i = 0; i < 4; i++)
      step(0, 1, 8'($urandom), 1, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      s  = ($urandom_range(0, 11) == 0) && !m_ack;
      cd = $urandom_range(0, 20);
      step($urandom_range(0, 299) == 0,
           $urandom_range(0, 3) != 0,
           8'($urandom), bit'($urandom), s, cd);
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
